// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host frame receiver with odd-parity/stop checks
// feeding a first-word-fall-through byte FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ps2_clk_i,
  input  logic          ps2_dat_i,
  input  logic          rd_i,
  input  logic          err_clr_i,
  output logic [7:0]    rdata_o,
  output logic          valid_o,
  output logic [AW:0]   count_o,
  output logic          irq_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          overflow_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(FIFO_DEPTH);

  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev;
  logic        fall, dat;

  state_t      state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  sr, sr_n;
  logic        ok, ok_n;
  logic [15:0] tcnt, tcnt_n;
  logic        push, perr_set, ferr_set;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, do_push, do_pop, ovf_set;

  // Pins are asynchronous; resetting the synchronizers high matches the idle bus level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_i};
      dat_sync <= {dat_sync[0], ps2_dat_i};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      sr      <= 8'h00;
      ok      <= 1'b0;
      tcnt    <= 16'd0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      sr      <= sr_n;
      ok      <= ok_n;
      tcnt    <= tcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    ok_n      = ok;
    tcnt_n    = tcnt + 16'd1;
    push      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    if (state == IDLE || fall) tcnt_n = 16'd0;
    if (fall) begin
      case (state)
        IDLE: if (!dat) begin
          state_n   = DATA;
          bit_cnt_n = 3'd0;
        end
        DATA: begin
          sr_n      = {dat, sr[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          ok_n    = ^{sr, dat};
          state_n = STOP;
        end
        STOP: begin
          state_n  = IDLE;
          push     = dat & ok;
          perr_set = ~ok;
          ferr_set = ~dat;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TO_LAST) begin
      // Stalled device: drop the partial byte and resynchronise on the next start bit.
      state_n  = IDLE;
      ferr_set = 1'b1;
    end
  end

  assign count_o = wr_ptr - rd_ptr;
  assign valid_o = (count_o != '0);
  assign irq_o   = valid_o;
  assign full    = (count_o == DEPTH_W);
  assign do_pop  = rd_i & valid_o;
  assign do_push = push & (~full | do_pop);
  assign ovf_set = push & full & ~do_pop;
  assign rdata_o = valid_o ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= sr;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // A set in the same cycle as a clear takes precedence.
      parity_err_o <= perr_set | (parity_err_o & ~err_clr_i);
      frame_err_o  <= ferr_set | (frame_err_o  & ~err_clr_i);
      overflow_o   <= ovf_set  | (overflow_o   & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed frames against a queue-based model of the PS/2 receiver FIFO.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       rst_n, ps2_clk, ps2_dat, rd, err_clr;
  logic [7:0] rdata;
  logic       valid, irq, perr, ferr, ovf;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic       m_perr, m_ferr, m_ovf;
  bit         hold;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .rd_i(rd), .err_clr_i(err_clr), .rdata_o(rdata), .valid_o(valid),
    .count_o(count), .irq_o(irq), .parity_err_o(perr), .frame_err_o(ferr),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model whenever no frame is settling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!hold) begin
        chk("valid", {31'd0, valid}, {31'd0, mq.size() != 0});
        chk("irq", {31'd0, irq}, {31'd0, mq.size() != 0});
        chk("count", {28'd0, count}, 32'(mq.size()));
        if (mq.size() != 0) chk("rdata", {24'd0, rdata}, {24'd0, mq[0]});
        chk("parity_err", {31'd0, perr}, {31'd0, m_perr});
        chk("frame_err", {31'd0, ferr}, {31'd0, m_ferr});
        chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
      end
    end
  end

  function automatic void model_frame(input logic [7:0] d, input logic p, input logic s,
                                      input bit popped);
    bit good;
    good = ((^d) ^ p) == 1'b1;
    if (popped && mq.size() > 0) void'(mq.pop_front());
    if (!good) m_perr = 1'b1;
    if (!s) m_ferr = 1'b1;
    if (s && good) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // With pop_at_stop, rd is high exactly in the cycle the stop-bit push lands
  // (third rising edge after the pin falls).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    ps2_dat = s;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    hold = 1'b1;
    if (pop_at_stop) begin
      repeat (2) @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    model_frame(d, p, s, pop_at_stop);
    hold = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(i[0]);
    ps2_dat = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk);
    rd = 1'b1;
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst irq", {31'd0, irq}, 32'd0);
    chk("rst count", {28'd0, count}, 32'd0);
    chk("rst rdata", {24'd0, rdata}, 32'd0);
    chk("rst flags", {29'd0, perr, ferr, ovf}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    hold = 1'b1;
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0; err_clr = 1'b0;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    hold = 1'b0;

    send_frame(8'h1C, 1'b0, 1'b1, 0);
    chk("t1 rdata", {24'd0, rdata}, 32'h1C);
    chk("t1 count", {28'd0, count}, 32'd1);
    pop();
    chk("t1 valid after pop", {31'd0, valid}, 32'd0);

    send_frame(8'h1C, 1'b1, 1'b1, 0);
    chk("t2 count", {28'd0, count}, 32'd0);
    chk("t2 parity_err", {31'd0, perr}, 32'd1);
    clear_flags();
    chk("t2 parity_err cleared", {31'd0, perr}, 32'd0);

    send_frame(8'hF0, 1'b1, 1'b0, 0);
    chk("t3 frame_err", {31'd0, ferr}, 32'd1);
    chk("t3 parity_err", {31'd0, perr}, 32'd0);
    chk("t3 count", {28'd0, count}, 32'd0);
    clear_flags();

    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, ~^d, 1'b1, 0);
    end
    chk("t4 count", {28'd0, count}, 32'd8);
    chk("t4 overflow", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t4 pop order", {24'd0, rdata}, 32'(i + 1));
      pop();
    end
    chk("t4 drained", {31'd0, valid}, 32'd0);
    pop();
    chk("t4 pop empty", {28'd0, count}, 32'd0);
    clear_flags();

    for (int i = 0; i < 8; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, ~^d, 1'b1, 0);
    end
    send_frame(8'h20, 1'b0, 1'b1, 1);
    chk("t6 count", {28'd0, count}, 32'd8);
    chk("t6 overflow", {31'd0, ovf}, 32'd0);
    chk("t6 head", {24'd0, rdata}, 32'h11);
    for (int i = 0; i < 7; i++) pop();
    chk("t6 tail", {24'd0, rdata}, 32'h20);
    pop();

    send_partial(4);
    hold = 1'b1;
    repeat (TO + 20) @(negedge clk);
    m_ferr = 1'b1;
    hold = 1'b0;
    chk("t5 timeout frame_err", {31'd0, ferr}, 32'd1);
    chk("t5 no push", {28'd0, count}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    chk("t5 rdata", {24'd0, rdata}, 32'h5A);

    send_partial(3);
    hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    hold = 1'b0;
    send_frame(8'h29, 1'b0, 1'b1, 0);
    chk("t6 post-reset rdata", {24'd0, rdata}, 32'h29);
    chk("t6 post-reset count", {28'd0, count}, 32'd1);
    chk("t6 post-reset flags", {29'd0, perr, ferr, ovf}, 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
